// File: rtl/vblank_arbiter_pkg.sv
// vblank_arbiter_pkg
// Shared definitions for the vertical-blank arbiter slice:
//   - SVGA 800x600 timing constants (the arbiter only consumes vblnk, but the
//     numbers document the window the arbiter works inside)
//   - arbiter FSM state encoding
//   - frame counter width
//   - one-hot to index helper used when recording the last granted requester
package vblank_arbiter_pkg;

  // Horizontal timing in pixel clocks.
  localparam int H_VISIBLE     = 800;
  localparam int H_TOTAL       = 1056;
  localparam int H_BLANK_START = 800;
  localparam int H_SYNC_START  = 840;
  localparam int H_SYNC_WIDTH  = 128;

  // Vertical timing in lines.
  localparam int V_VISIBLE     = 600;
  localparam int V_TOTAL       = 628;
  localparam int V_BLANK_START = 600;
  localparam int V_SYNC_START  = 601;
  localparam int V_SYNC_WIDTH  = 4;

  // Completed-frame counter width.
  localparam int FRAME_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARB   = 2'd1,
    ST_GRANT = 2'd2
  } arb_state_t;

  // Index of the highest set bit of a one-hot vector (up to 8 requesters).
  function automatic logic [2:0] onehot_idx(input logic [7:0] oh);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (oh[i]) begin
        idx = 3'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/vblank_arbiter_if.sv
// vblank_arbiter_if
// Request/grant bundle between frame-update requesters and the arbiter.
//   vblnk     : vertical blank from the timing generator (registered in pclk)
//   req       : level request per requester, held until served
//   done      : one-cycle completion pulse from the granted requester
//   grant     : one-hot or zero grant vector
//   busy      : a grant is currently held
//   frame_cnt : completed-frame count
//   timeout   : pulse when a slot was forcibly ended
//   overrun   : pulse when blanking ended while a grant was held
//   missed    : requesters still pending when the window closed
// Modports: master drives the requests, slave is the arbiter.
interface vblank_arbiter_if
  import vblank_arbiter_pkg::*;
#(
  parameter int N_REQ = 4
) ();

  logic                 vblnk;
  logic [N_REQ-1:0]     req;
  logic [N_REQ-1:0]     done;
  logic [N_REQ-1:0]     grant;
  logic                 busy;
  logic [FRAME_W-1:0]   frame_cnt;
  logic                 timeout;
  logic                 overrun;
  logic [N_REQ-1:0]     missed;

  modport master (
    output vblnk, req, done,
    input  grant, busy, frame_cnt, timeout, overrun, missed
  );

  modport slave (
    input  vblnk, req, done,
    output grant, busy, frame_cnt, timeout, overrun, missed
  );

endinterface

// File: rtl/vblank_arbiter_rr_picker.sv
// rr_picker
// Combinational round-robin priority encoder. Starting just after i_last and
// wrapping, selects the first set bit of i_eligible.
//   i_eligible : candidate requesters
//   i_last     : index of the most recently granted requester
//   o_pick     : one-hot selection (zero when nothing eligible)
//   o_valid    : a requester was selected
module rr_picker #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         i_eligible,
  input  logic [$clog2(N_REQ)-1:0] i_last,
  output logic [N_REQ-1:0]         o_pick,
  output logic                     o_valid
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int SUM_W = IDX_W + 1;

  logic [SUM_W-1:0] w_sum;

  // Scan N_REQ positions after i_last; last + k never exceeds 2*N_REQ-1, so a
  // single conditional subtraction performs the wrap.
  always_comb begin
    o_pick  = '0;
    o_valid = 1'b0;
    w_sum   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      w_sum = {1'b0, i_last} + SUM_W'(k);
      if (w_sum >= SUM_W'(N_REQ)) begin
        w_sum = w_sum - SUM_W'(N_REQ);
      end else begin
        w_sum = w_sum;
      end
      if (!o_valid && i_eligible[w_sum[IDX_W-1:0]]) begin
        o_pick[w_sum[IDX_W-1:0]] = 1'b1;
        o_valid                  = 1'b1;
      end else begin
        o_valid = o_valid;
      end
    end
  end

endmodule

// File: rtl/vblank_arbiter.sv
// vblank_arbiter
// Round-robin scheduler that hands exclusive access to shared drawing state
// to one requester at a time, only while vertical blanking is active. Counts
// frames, ends over-long slots and reports requesters that overran or missed
// the blanking window.
//   pclk  : pixel clock
//   rst_n : asynchronous active-low reset
//   bus   : vblank_arbiter_if slave (vblnk/req/done in, grant/status out)
module vblank_arbiter
  import vblank_arbiter_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int MAX_SLOT = 4096,
  parameter int SLOT_W   = 13
) (
  input  logic            pclk,
  input  logic            rst_n,
  vblank_arbiter_if.slave bus
);

  localparam int IDX_W = $clog2(N_REQ);

  arb_state_t         r_state, w_state_nxt;
  logic               r_vblnk_q, r_q_valid;
  logic               w_rise, w_fall;
  logic [N_REQ-1:0]   r_served, w_served_nxt;
  logic [N_REQ-1:0]   r_missed, w_missed_nxt;
  logic [N_REQ-1:0]   r_grant, w_grant_nxt;
  logic [N_REQ-1:0]   w_eligible, w_pick;
  logic               w_pick_valid, w_done_g, w_slot_end;
  logic [IDX_W-1:0]   r_last, w_last_nxt;
  logic [SLOT_W-1:0]  r_slot, w_slot_nxt;
  logic [FRAME_W-1:0] r_frame_cnt, w_frame_nxt;
  logic               r_busy, r_timeout, r_overrun;
  logic               w_timeout_nxt, w_overrun_nxt;

  // r_q_valid masks the first cycle after reset, where r_vblnk_q holds its
  // reset value rather than a real sample; otherwise a reset released inside
  // blanking would be mistaken for a rising edge and open a partial window.
  assign w_rise     = bus.vblnk & ~r_vblnk_q & r_q_valid;
  assign w_fall     = ~bus.vblnk & r_vblnk_q & r_q_valid;
  assign w_eligible = bus.req & ~r_served;
  assign w_done_g   = |(bus.done & r_grant);
  assign w_slot_end = (r_slot == SLOT_W'(MAX_SLOT - 1));

  rr_picker #(.N_REQ(N_REQ)) u_picker (
    .i_eligible (w_eligible),
    .i_last     (r_last),
    .o_pick     (w_pick),
    .o_valid    (w_pick_valid)
  );

  // FSM state register.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic; closing of the window outranks a new grant.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_rise) w_state_nxt = ST_ARB;
        else        w_state_nxt = ST_IDLE;
      end
      ST_ARB: begin
        if (w_fall)            w_state_nxt = ST_IDLE;
        else if (w_pick_valid) w_state_nxt = ST_GRANT;
        else                   w_state_nxt = ST_ARB;
      end
      ST_GRANT: begin
        if (w_done_g)        w_state_nxt = w_fall ? ST_IDLE : ST_ARB;
        else if (w_fall)     w_state_nxt = ST_IDLE;
        else if (w_slot_end) w_state_nxt = ST_ARB;
        else                 w_state_nxt = ST_GRANT;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM output logic: next values of grant, bookkeeping and status pulses.
  always_comb begin
    w_grant_nxt   = r_grant;
    w_served_nxt  = r_served;
    w_missed_nxt  = r_missed;
    w_last_nxt    = r_last;
    w_frame_nxt   = r_frame_cnt;
    w_slot_nxt    = '0;
    w_timeout_nxt = 1'b0;
    w_overrun_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_rise) begin
          w_frame_nxt  = r_frame_cnt + 16'd1;
          w_served_nxt = '0;
          w_missed_nxt = '0;
        end else begin
          w_frame_nxt = r_frame_cnt;
        end
      end
      ST_ARB: begin
        if (w_fall) begin
          w_missed_nxt = w_eligible;
        end else if (w_pick_valid) begin
          w_grant_nxt  = w_pick;
          w_served_nxt = r_served | w_pick;
          w_last_nxt   = IDX_W'(onehot_idx(8'(w_pick)));
        end else begin
          w_grant_nxt = '0;
        end
      end
      ST_GRANT: begin
        w_slot_nxt = r_slot + SLOT_W'(1);
        if (w_done_g) begin
          w_grant_nxt = '0;
          if (w_fall) w_missed_nxt = w_eligible;
          else        w_missed_nxt = r_missed;
        end else if (w_fall) begin
          w_grant_nxt   = '0;
          w_overrun_nxt = 1'b1;
          w_missed_nxt  = w_eligible;
        end else if (w_slot_end) begin
          w_grant_nxt   = '0;
          w_timeout_nxt = 1'b1;
        end else begin
          w_grant_nxt = r_grant;
        end
      end
      default: begin
        w_grant_nxt = '0;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_vblnk_q   <= 1'b0;
      r_q_valid   <= 1'b0;
      r_grant     <= '0;
      r_busy      <= 1'b0;
      r_served    <= '0;
      r_missed    <= '0;
      r_last      <= IDX_W'(N_REQ - 1);
      r_slot      <= '0;
      r_frame_cnt <= '0;
      r_timeout   <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_vblnk_q   <= bus.vblnk;
      r_q_valid   <= 1'b1;
      r_grant     <= w_grant_nxt;
      r_busy      <= |w_grant_nxt;
      r_served    <= w_served_nxt;
      r_missed    <= w_missed_nxt;
      r_last      <= w_last_nxt;
      r_slot      <= w_slot_nxt;
      r_frame_cnt <= w_frame_nxt;
      r_timeout   <= w_timeout_nxt;
      r_overrun   <= w_overrun_nxt;
    end
  end

  assign bus.grant     = r_grant;
  assign bus.busy      = r_busy;
  assign bus.frame_cnt = r_frame_cnt;
  assign bus.timeout   = r_timeout;
  assign bus.overrun   = r_overrun;
  assign bus.missed    = r_missed;

endmodule

// File: tb/tb_vblank_arbiter.sv
// tb_vblank_arbiter
// Directed scenarios for the vertical-blank arbiter followed by randomized
// frames checked cycle by cycle against a behavioural model.
module tb_vblank_arbiter;
  import vblank_arbiter_pkg::*;

  localparam int N    = 4;
  localparam int MAXS = 16;

  logic pclk  = 1'b0;
  logic rst_n = 1'b0;

  vblank_arbiter_if #(.N_REQ(N)) bus ();

  vblank_arbiter #(.N_REQ(N), .MAX_SLOT(MAXS), .SLOT_W(5)) dut (
    .pclk  (pclk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 pclk = ~pclk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Stimulus state: vblnk level, request levels, per-requester done delay
  // (cycles after its grant appears; 0 = never answers).
  logic         vb;
  logic [N-1:0] req_v;
  int           dly[N];
  logic [N-1:0] prev_g;
  int           gcnt;

  // Behavioural model state.
  logic         m_vq, m_qv, m_open, m_to, m_ov;
  int           m_g, m_held, m_last;
  logic [N-1:0] m_served, m_missed;
  logic [15:0]  m_frame;

  task automatic model_reset();
    m_vq = 1'b0; m_qv = 1'b0; m_open = 1'b0; m_to = 1'b0; m_ov = 1'b0;
    m_g = -1; m_held = 0; m_last = N - 1;
    m_served = '0; m_missed = '0; m_frame = 16'd0;
  endtask

  // One clock of the arbiter as described: window opens on vblnk rising,
  // one holder at a time, holder leaves on done / window close / slot expiry.
  task automatic model_step();
    logic rise, fall;
    logic [N-1:0] pend;
    rise = bus.vblnk && !m_vq && m_qv;
    fall = !bus.vblnk && m_vq && m_qv;
    pend = bus.req & ~m_served;
    m_to = 1'b0;
    m_ov = 1'b0;
    if (m_g >= 0) begin
      if (bus.done[m_g]) begin
        m_g = -1;
        if (fall) begin m_open = 1'b0; m_missed = pend; end
      end else if (fall) begin
        m_g = -1; m_open = 1'b0; m_ov = 1'b1; m_missed = pend;
      end else if (m_held == MAXS) begin
        m_g = -1; m_to = 1'b1;
      end else begin
        m_held++;
      end
    end else if (m_open) begin
      if (fall) begin
        m_open = 1'b0; m_missed = pend;
      end else if (pend != '0) begin
        for (int k = 1; k <= N; k++)
          if (m_g < 0 && pend[(m_last + k) % N]) m_g = (m_last + k) % N;
        m_served[m_g] = 1'b1;
        m_last = m_g;
        m_held = 1;
      end
    end else if (rise) begin
      m_open = 1'b1; m_frame = m_frame + 16'd1; m_served = '0; m_missed = '0;
    end
    m_vq = bus.vblnk;
    m_qv = 1'b1;
  endtask

  // One cycle: requesters answer grants, inputs applied, model advanced at the
  // edge, returns at the following negedge with outputs settled.
  task automatic step();
    logic [N-1:0] d;
    d = '0;
    if (bus.grant != '0) gcnt = (bus.grant == prev_g) ? gcnt + 1 : 1;
    else                 gcnt = 0;
    prev_g = bus.grant;
    for (int i = 0; i < N; i++) begin
      if (bus.grant[i] && dly[i] > 0 && gcnt == dly[i]) begin
        d[i] = 1'b1;
        req_v[i] = 1'b0;
      end
    end
    bus.done  = d;
    bus.req   = req_v;
    bus.vblnk = vb;
    @(posedge pclk);
    if (rst_n) model_step();
    else       model_reset();
    @(negedge pclk);
    cyc++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; vb = 1'b0; req_v = '0;
    bus.vblnk = 1'b0; bus.req = '0; bus.done = '0;
    prev_g = '0; gcnt = 0;
    for (int i = 0; i < N; i++) dly[i] = 3;
    model_reset();
    repeat (3) @(negedge pclk);
    tests++;
    if (bus.grant !== 4'b0000 || bus.busy !== 1'b0) begin
      fails++; $display("FAIL reset_grant: got grant=%b busy=%b want 0000/0", bus.grant, bus.busy);
    end
    tests++;
    if (bus.frame_cnt !== 16'd0 || bus.missed !== 4'b0000) begin
      fails++; $display("FAIL reset_frame_missed: got %h/%b want 0000/0000", bus.frame_cnt, bus.missed);
    end
    tests++;
    if (bus.timeout !== 1'b0 || bus.overrun !== 1'b0) begin
      fails++; $display("FAIL reset_pulses: got to=%b ov=%b want 0/0", bus.timeout, bus.overrun);
    end
    rst_n = 1'b1;
    repeat (2) step();
  endtask

  task automatic test_rr_order();
    logic [N-1:0] seq[$];
    int at[$];
    logic [N-1:0] pg;
    int vstep;
    pg = '0; vb = 1'b1; req_v = 4'b1111;
    for (int i = 0; i < N; i++) dly[i] = 3;
    vstep = cyc;
    for (int s = 0; s < 22; s++) begin
      step();
      if (bus.grant != '0 && bus.grant != pg) begin seq.push_back(bus.grant); at.push_back(cyc); end
      pg = bus.grant;
    end
    tests++;
    if (seq.size() != 4) begin
      fails++; $display("FAIL rr_count: got %0d grants want 4", seq.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        tests++;
        if (seq[k] !== 4'(1 << k)) begin
          fails++; $display("FAIL rr_order[%0d]: got %b want %b", k, seq[k], 4'(1 << k));
        end
      end
      tests++;
      if (at[0] - vstep != 2) begin
        fails++; $display("FAIL first_grant_latency: got %0d want 2", at[0] - vstep);
      end
      for (int k = 0; k < 3; k++) begin
        tests++;
        if (at[k+1] - at[k] != 4) begin
          fails++; $display("FAIL dead_cycle[%0d]: got spacing %0d want 4 (3 held + 1 idle)", k, at[k+1] - at[k]);
        end
      end
    end
    vb = 1'b0;
    repeat (2) step();
    tests++;
    if (bus.frame_cnt !== 16'd1 || bus.missed !== 4'b0000) begin
      fails++; $display("FAIL frame1_end: got frame=%0d missed=%b want 1/0000", bus.frame_cnt, bus.missed);
    end
  endtask

  task automatic test_late_request();
    logic [N-1:0] seq[$];
    logic [N-1:0] pg;
    pg = '0; vb = 1'b1; req_v = 4'b0001;
    for (int s = 0; s < 125; s++) begin
      if (s == 100) req_v[2] = 1'b1;
      step();
      if (bus.grant != '0 && bus.grant != pg) seq.push_back(bus.grant);
      pg = bus.grant;
    end
    vb = 1'b0;
    repeat (2) step();
    tests++;
    if (seq.size() != 2 || seq[0] !== 4'b0001 || seq[1] !== 4'b0100) begin
      fails++; $display("FAIL late_order: got %0d grants first=%b want 0001 then 0100",
                        seq.size(), (seq.size() > 0) ? seq[0] : 4'b0000);
    end
    tests++;
    if (bus.missed !== 4'b0000 || bus.frame_cnt !== 16'd2) begin
      fails++; $display("FAIL late_end: got missed=%b frame=%0d want 0000/2", bus.missed, bus.frame_cnt);
    end
  endtask

  task automatic test_timeout();
    logic [N-1:0] seq[$];
    int at[$];
    logic [N-1:0] pg;
    int hi1, last1, to_at, to_n;
    pg = '0; hi1 = 0; last1 = -1; to_at = -1; to_n = 0;
    vb = 1'b1; req_v = 4'b0110; dly[1] = 0; dly[2] = 3;
    for (int s = 0; s < 40; s++) begin
      step();
      if (bus.grant === 4'b0010) begin hi1++; last1 = cyc; end
      if (bus.timeout === 1'b1) begin to_n++; to_at = cyc; end
      if (bus.grant != '0 && bus.grant != pg) begin seq.push_back(bus.grant); at.push_back(cyc); end
      pg = bus.grant;
    end
    tests++;
    if (hi1 != MAXS) begin
      fails++; $display("FAIL timeout_hold: got %0d cycles want %0d", hi1, MAXS);
    end
    tests++;
    if (to_n != 1 || to_at != last1 + 1) begin
      fails++; $display("FAIL timeout_pulse: got %0d pulses at +%0d want 1 at +1", to_n, to_at - last1);
    end
    tests++;
    if (seq.size() != 2 || seq[0] !== 4'b0010 || seq[1] !== 4'b0100 || at[1] != to_at + 1) begin
      fails++; $display("FAIL timeout_next: got %0d grants second=%b want 0010 then 0100 right after timeout",
                        seq.size(), (seq.size() > 1) ? seq[1] : 4'b0000);
    end
    vb = 1'b0;
    step();
    tests++;
    if (bus.missed !== 4'b0000) begin
      fails++; $display("FAIL timeout_missed: got %b want 0000", bus.missed);
    end
    req_v = '0; dly[1] = 3;
    step();
  endtask

  task automatic test_overrun();
    int n;
    vb = 1'b1; req_v = 4'b1000; dly[3] = 0; n = 0;
    do begin step(); n++; end while (bus.grant !== 4'b1000 && n < 10);
    tests++;
    if (bus.grant !== 4'b1000) begin
      fails++; $display("FAIL overrun_setup: got grant=%b want 1000", bus.grant);
    end
    req_v = req_v | 4'b0011;
    repeat (3) step();
    vb = 1'b0;
    step();
    tests++;
    if (bus.overrun !== 1'b1 || bus.grant !== 4'b0000 || bus.busy !== 1'b0) begin
      fails++; $display("FAIL overrun_pulse: got ov=%b grant=%b busy=%b want 1/0000/0", bus.overrun, bus.grant, bus.busy);
    end
    tests++;
    if (bus.missed !== 4'b0011) begin
      fails++; $display("FAIL overrun_missed: got %b want 0011", bus.missed);
    end
    for (int s = 0; s < 5; s++) begin
      step();
      tests++;
      if (bus.grant !== 4'b0000 || bus.overrun !== 1'b0) begin
        fails++; $display("FAIL overrun_idle: got grant=%b ov=%b want 0000/0", bus.grant, bus.overrun);
      end
    end
    req_v = '0; dly[3] = 3;
  endtask

  task automatic test_frame_wrap();
    vb = 1'b0; req_v = '0;
    force dut.r_frame_cnt = 16'hFFFF;
    step();
    release dut.r_frame_cnt;
    step();
    tests++;
    if (bus.frame_cnt !== 16'hFFFF) begin
      fails++; $display("FAIL wrap_preload: got %h want ffff", bus.frame_cnt);
    end
    vb = 1'b1;
    step();
    tests++;
    if (bus.frame_cnt !== 16'h0000) begin
      fails++; $display("FAIL wrap: got %h want 0000", bus.frame_cnt);
    end
    vb = 1'b0;
    repeat (2) step();
  endtask

  task automatic test_reset_mid_grant();
    int n;
    vb = 1'b1; req_v = 4'b0001; dly[0] = 0; n = 0;
    do begin step(); n++; end while (bus.grant !== 4'b0001 && n < 10);
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (bus.grant !== 4'b0000 || bus.busy !== 1'b0 || bus.frame_cnt !== 16'd0 ||
        bus.missed !== 4'b0000 || bus.timeout !== 1'b0 || bus.overrun !== 1'b0) begin
      fails++; $display("FAIL async_reset: got grant=%b busy=%b frame=%h want all zero", bus.grant, bus.busy, bus.frame_cnt);
    end
    @(negedge pclk);
    repeat (2) step();
    rst_n = 1'b1;
    for (int s = 0; s < 8; s++) begin
      step();
      tests++;
      if (bus.grant !== 4'b0000) begin
        fails++; $display("FAIL no_partial_window: got grant=%b want 0000", bus.grant);
      end
    end
    vb = 1'b0; step();
    vb = 1'b1; repeat (2) step();
    tests++;
    if (bus.grant !== 4'b0001 || bus.frame_cnt !== 16'd1) begin
      fails++; $display("FAIL post_reset_grant: got grant=%b frame=%0d want 0001/1", bus.grant, bus.frame_cnt);
    end
    vb = 1'b0; req_v = '0; dly[0] = 3;
    repeat (2) step();
  endtask

  task automatic test_random();
    logic [N-1:0] eg;
    rst_n = 1'b0; vb = 1'b0; req_v = '0;
    repeat (2) step();
    rst_n = 1'b1;
    for (int f = 0; f < 10; f++) begin
      for (int i = 0; i < N; i++) dly[i] = $urandom_range(0, 6);
      for (int ph = 0; ph < 2; ph++) begin
        vb = (ph == 1);
        if (ph == 1) req_v = req_v | 4'($urandom_range(0, 15));
        for (int s = 0; s < ((ph == 0) ? int'($urandom_range(1, 4)) : int'($urandom_range(10, 120))); s++) begin
          if ($urandom_range(0, 5) == 0) req_v[$urandom_range(0, N - 1)] = 1'b1;
          step();
          eg = '0;
          if (m_g >= 0) eg[m_g] = 1'b1;
          tests++;
          if (bus.grant !== eg) begin
            fails++; $display("FAIL rand_grant cyc %0d: got %b want %b", cyc, bus.grant, eg);
          end
          tests++;
          if (bus.busy !== (m_g >= 0)) begin
            fails++; $display("FAIL rand_busy cyc %0d: got %b want %b", cyc, bus.busy, (m_g >= 0));
          end
          tests++;
          if (bus.timeout !== m_to || bus.overrun !== m_ov) begin
            fails++; $display("FAIL rand_pulses cyc %0d: got to=%b ov=%b want %b/%b", cyc, bus.timeout, bus.overrun, m_to, m_ov);
          end
          tests++;
          if (bus.missed !== m_missed || bus.frame_cnt !== m_frame) begin
            fails++; $display("FAIL rand_status cyc %0d: got missed=%b frame=%0d want %b/%0d",
                              cyc, bus.missed, bus.frame_cnt, m_missed, m_frame);
          end
        end
      end
    end
    vb = 1'b0; req_v = '0;
    repeat (2) step();
  endtask

  initial begin
    test_reset();
    test_rr_order();
    test_late_request();
    test_timeout();
    test_overrun();
    test_frame_wrap();
    test_reset_mid_grant();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

endmodule
